// File: rtl/repo_read_arbiter.sv
// Round-robin read arbiter sharing one task-repository read port among N_REQ requesters.
// One burst is granted at a time; addresses stream one word per cycle, data is routed back to the owner.
module repo_read_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 30,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 8,
   parameter int MEM_LAT = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*LEN_W-1:0]    req_len,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_last,
   output logic                      mem_rd,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [DATA_W-1:0]         mem_data,
   output logic                      busy
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [MEM_LAT-1:0] EXIT_BIT = MEM_LAT'(1) << (MEM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0]   owner, owner_nxt;
   logic [ADDR_W-1:0]  cur, cur_nxt;
   logic [LEN_W-1:0]   cnt, cnt_nxt;

   logic [PTR_W-1:0]   winner;
   logic               grant_any;
   logic               issue_word;
   logic               issue_last;
   logic               pending;

   logic [ADDR_W-1:0]  addr_slice [N_REQ];
   logic [LEN_W-1:0]   len_slice  [N_REQ];

   logic [MEM_LAT-1:0] pipe_valid;
   logic [MEM_LAT-1:0] pipe_last;
   logic [PTR_W-1:0]   pipe_owner [MEM_LAT];

   always_comb begin : unpack_requests
      for (int i = 0; i < N_REQ; i++) begin
         addr_slice[i] = req_addr[i*ADDR_W +: ADDR_W];
         len_slice[i]  = req_len[i*LEN_W +: LEN_W];
      end
   end

   // First asserted requester at or after rr_ptr, wrapping around.
   always_comb begin : arbitrate
      int idx;
      winner    = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (!grant_any && req_valid[idx]) begin
            grant_any = 1'b1;
            winner    = PTR_W'(idx);
         end
      end
   end

   // NOTE: every signal this block drives gets a default before the case, so no latch is inferred.
   always_comb begin : next_state
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      owner_nxt  = owner;
      cur_nxt    = cur;
      cnt_nxt    = cnt;
      req_ready  = '0;
      issue_word = 1'b0;
      issue_last = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant_any && !reset) begin
               req_ready[winner] = 1'b1;
               cur_nxt    = addr_slice[winner] & ~ADDR_W'(3);
               cnt_nxt    = len_slice[winner];
               owner_nxt  = winner;
               rr_ptr_nxt = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
               state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            issue_word = 1'b1;
            issue_last = (cnt == '0);
            cur_nxt    = cur + ADDR_W'(4);
            if (cnt == '0) begin
               state_nxt = DRAIN;
            end else begin
               cnt_nxt = cnt - LEN_W'(1);
            end
         end
         DRAIN: begin
            // The word leaving the pipeline this cycle does not hold us; IDLE follows the last response.
            if (!pending) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin : state_reg
      if (reset) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
         cur    <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         owner  <= owner_nxt;
         cur    <= cur_nxt;
         cnt    <= cnt_nxt;
      end
   end

   // NOTE: the latency pipeline is only MEM_LAT entries of flops, so it is cleared on reset;
   // that is what guarantees an aborted burst produces no further responses.
   always_ff @(posedge clock or posedge reset) begin : latency_pipe
      if (reset) begin
         pipe_valid <= '0;
         pipe_last  <= '0;
         for (int i = 0; i < MEM_LAT; i++) begin
            pipe_owner[i] <= '0;
         end
      end else begin
         pipe_valid[0] <= issue_word;
         pipe_last[0]  <= issue_last;
         pipe_owner[0] <= owner;
         for (int i = 1; i < MEM_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_last[i]  <= pipe_last[i-1];
            pipe_owner[i] <= pipe_owner[i-1];
         end
      end
   end

   assign pending = |(pipe_valid & ~EXIT_BIT);

   always_comb begin : response_route
      rsp_valid = '0;
      if (pipe_valid[MEM_LAT-1]) begin
         rsp_valid[pipe_owner[MEM_LAT-1]] = 1'b1;
      end
   end

   assign rsp_last = pipe_valid[MEM_LAT-1] & pipe_last[MEM_LAT-1];
   assign rsp_data = mem_data;
   assign mem_rd   = (state == ISSUE);
   assign mem_addr = cur;
   assign busy     = (state != IDLE) || (|pipe_valid);

endmodule

// File: tb/tb_repo_read_arbiter.sv
// Bench for repo_read_arbiter: a grant-level reference model pushes expected addresses and responses
// into queues; a separate monitor pops and compares them. A second instance covers MEM_LAT=3.
module tb_repo_read_arbiter;

   localparam int N     = 4;
   localparam int AW    = 30;
   localparam int DW    = 32;
   localparam int LW    = 8;
   localparam int LAT   = 1;
   localparam int LAT_B = 3;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            owner;
      logic          last;
   } exp_t;

   logic clock;
   logic reset;

   // Instance A (MEM_LAT=1) stimulus and outputs.
   logic [N-1:0]    rv;
   logic [AW-1:0]   ra [N];
   logic [LW-1:0]   rl [N];
   logic [N*AW-1:0] req_addr;
   logic [N*LW-1:0] req_len;
   logic [N-1:0]    req_ready, rsp_valid;
   logic [DW-1:0]   rsp_data, mem_data;
   logic            rsp_last, mem_rd, busy;
   logic [AW-1:0]   mem_addr;

   // Instance B (MEM_LAT=3).
   logic [N-1:0]    b_rv;
   logic [N*AW-1:0] b_req_addr;
   logic [N*LW-1:0] b_req_len;
   logic [N-1:0]    b_req_ready, b_rsp_valid;
   logic [DW-1:0]   b_rsp_data, b_mem_data;
   logic            b_rsp_last, b_mem_rd, b_busy;
   logic [AW-1:0]   b_mem_addr;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   exp_t mem_q[$];
   exp_t rsp_q[$];
   int   ptr        = 0;
   int   free_cycle = 0;
   int   busy_from  = 0;
   logic [N-1:0] grant_seen = '0;
   logic [N-1:0] hold       = '0;
   bit           rand_mode  = 1'b0;

   logic [AW-1:0] lat_a [LAT];
   logic [AW-1:0] lat_b [LAT_B];

   repo_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MEM_LAT(LAT)) dut (
      .clock(clock), .reset(reset),
      .req_valid(rv), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
   );

   repo_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MEM_LAT(LAT_B)) dut_b (
      .clock(clock), .reset(reset),
      .req_valid(b_rv), .req_addr(b_req_addr), .req_len(b_req_len), .req_ready(b_req_ready),
      .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_last(b_rsp_last),
      .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_data(b_mem_data), .busy(b_busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW] = ra[i];
         req_len[i*LW +: LW]  = rl[i];
      end
   end

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      logic [31:0] w;
      w = 32'(a >> 2);
      return (w * 32'h9E37_79B1) ^ 32'hC3A5_0000;
   endfunction

   // Repository models: the address sampled with mem_rd appears as data MEM_LAT cycles later.
   always @(posedge clock) begin
      lat_a[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) lat_a[i] <= lat_a[i-1];
      lat_b[0] <= b_mem_addr;
      for (int i = 1; i < LAT_B; i++) lat_b[i] <= lat_b[i-1];
   end
   assign mem_data   = mem_word(lat_a[LAT-1]);
   assign b_mem_data = mem_word(lat_b[LAT_B-1]);

   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: decides each grant from the round-robin rule and the bench's own requests,
   // then expands the burst into its expected address and response stream.
   always @(negedge clock) begin : ref_model
      logic [N-1:0] exp_ready;
      int w;
      exp_t e;
      if (reset) begin
         mem_q.delete();
         rsp_q.delete();
         ptr        = 0;
         free_cycle = 0;
         busy_from  = 0;
         grant_seen = '0;
      end else begin
         exp_ready = '0;
         if (cyc >= free_cycle && rv != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
               if (w < 0 && rv[(ptr + k) % N]) w = (ptr + k) % N;
            end
            exp_ready[w] = 1'b1;
            for (int k = 0; k <= int'(rl[w]); k++) begin
               e.addr  = {ra[w][AW-1:2], 2'b00} + AW'(4 * k);
               e.data  = mem_word(e.addr);
               e.owner = w;
               e.last  = (k == int'(rl[w]));
               e.cyc   = cyc + 1 + k;
               mem_q.push_back(e);
               e.cyc   = cyc + 1 + LAT + k;
               rsp_q.push_back(e);
            end
            ptr        = (w + 1) % N;
            busy_from  = cyc + 1;
            free_cycle = cyc + 2 + LAT + int'(rl[w]);
         end
         check("req_ready", req_ready, exp_ready);
         grant_seen = req_ready;
      end
   end

   always @(negedge clock) begin : monitor
      exp_t e;
      logic [N-1:0] ev;
      if (reset) begin
         check("rst_req_ready", req_ready, 0);
         check("rst_rsp", {rsp_valid, rsp_last}, 0);
         check("rst_mem_rd", mem_rd, 0);
         check("rst_mem_addr", mem_addr, 0);
         check("rst_busy", busy, 0);
      end else begin
         if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
            e = mem_q.pop_front();
            check("mem_rd", mem_rd, 1);
            check("mem_addr", mem_addr, e.addr);
         end else begin
            check("mem_rd_idle", mem_rd, 0);
         end
         if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
            e = rsp_q.pop_front();
            ev = '0;
            ev[e.owner] = 1'b1;
            check("rsp_valid", rsp_valid, ev);
            check("rsp_data", rsp_data, e.data);
            check("rsp_last", rsp_last, e.last);
         end else begin
            check("rsp_idle", {rsp_valid, rsp_last}, 0);
         end
         check("busy", busy, (cyc >= busy_from) && (cyc < free_cycle));
      end
   end

   task automatic new_req(input int i);
      ra[i]   = ($urandom_range(0, 9) == 0) ? (30'h3FFF_FFF0 | AW'($urandom_range(0, 15)))
                                            : AW'($urandom);
      rl[i]   = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(0, 3));
      hold[i] = 1'($urandom_range(0, 1));
      rv[i]   = 1'b1;
   endtask

   // Requester agents: drop or re-request after a grant, and in random mode raise/withdraw freely.
   always @(posedge clock) begin : agent
      #1;
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            if (grant_seen[i]) begin
               if (!hold[i]) rv[i] = 1'b0;
               else if (rand_mode) new_req(i);
            end else if (rand_mode) begin
               if (!rv[i] && $urandom_range(0, 5) == 0) new_req(i);
               else if (rv[i] && $urandom_range(0, 99) == 0) rv[i] = 1'b0;
            end
         end
      end
   end

   task automatic raise(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic h);
      @(posedge clock);
      #1;
      ra[i]   = a;
      rl[i]   = l;
      hold[i] = h;
      rv[i]   = 1'b1;
   endtask

   task automatic wait_grant(input int i);
      logic got;
      got = 1'b0;
      for (int n = 0; n < 600 && !got; n++) begin
         @(posedge clock);
         got = grant_seen[i];
      end
      check($sformatf("grant_wait_%0d", i), got, 1);
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int n = 0; n < 2000 && !done; n++) begin
         @(posedge clock);
         done = (rv == '0) && (mem_q.size() == 0) && (rsp_q.size() == 0);
      end
      repeat (2) @(posedge clock);
      check("idle_wait", done, 1);
   endtask

   // MEM_LAT=3 burst: len=2 at 0x8, checked cycle by cycle relative to the grant.
   task automatic run_b();
      logic got;
      logic exp_rd, exp_rsp;
      b_req_addr[AW-1:0] = 30'h8;
      b_req_len[LW-1:0]  = 8'd2;
      @(posedge clock);
      #1 b_rv = 4'b0001;
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clock);
         got = b_req_ready[0];
      end
      check("b_grant_wait", got, 1);
      check("b_req_ready", b_req_ready, 4'b0001);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clock);
         if (k == 1) #1 b_rv = '0;
         @(negedge clock);
         exp_rd  = (k >= 1) && (k <= 3);
         exp_rsp = (k >= 4) && (k <= 6);
         check("b_mem_rd", b_mem_rd, exp_rd);
         if (exp_rd) check("b_mem_addr", b_mem_addr, 30'h8 + AW'(4 * (k - 1)));
         check("b_rsp_valid", b_rsp_valid, exp_rsp ? 4'b0001 : 4'b0000);
         if (exp_rsp) check("b_rsp_data", b_rsp_data, mem_word(30'h8 + AW'(4 * (k - 4))));
         check("b_rsp_last", b_rsp_last, k == 6);
         check("b_busy", b_busy, k <= 6);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      rv    = '0;
      b_rv  = '0;
      b_req_addr = '0;
      b_req_len  = '0;
      for (int i = 0; i < N; i++) begin
         ra[i] = '0;
         rl[i] = '0;
      end
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Simultaneous single-word requests from 0, 1, 3 starting at rr_ptr=0.
      @(posedge clock);
      #1;
      ra[0] = 30'h10;  rl[0] = '0;
      ra[1] = 30'h20;  rl[1] = '0;
      ra[3] = 30'h30;  rl[3] = '0;
      rv    = 4'b1011;
      wait_grant(0);
      wait_grant(1);
      wait_grant(3);
      wait_idle();

      // Single 4-word burst from requester 2.
      raise(2, 30'h100, 8'd3, 1'b0);
      wait_grant(2);
      wait_idle();

      // Requester 1 holds continuously; requester 2 must be served before 1 again.
      raise(1, 30'h200, 8'd1, 1'b1);
      wait_grant(1);
      raise(2, 30'h300, 8'd0, 1'b0);
      wait_grant(2);
      wait_grant(1);
      hold[1] = 1'b0;
      wait_idle();

      // Address wrap at the top of the byte space, then a maximum-length burst.
      raise(0, 30'h3FFF_FFFC, 8'd1, 1'b0);
      wait_grant(0);
      wait_idle();
      raise(3, 30'h0001_0000, 8'hFF, 1'b0);
      wait_grant(3);
      wait_idle();

      // Reset during the third address of an 8-word burst, then a clean burst.
      raise(0, 30'h400, 8'd7, 1'b0);
      wait_grant(0);
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      raise(1, 30'h40, 8'd2, 1'b0);
      wait_grant(1);
      wait_idle();

      run_b();

      rand_mode = 1'b1;
      repeat (3000) @(posedge clock);
      rand_mode = 1'b0;
      hold      = '0;
      wait_idle();

      check("mem_q_drained", mem_q.size(), 0);
      check("rsp_q_drained", rsp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
